mod_count: RTL

Parametrised synchronous up/down modulo counter, the next generation of the lab's basic binary counter. It adds a direction control, a parallel load, a selectable wrap or saturate mode, and terminal-count and carry outputs. Multiple instances can be cascaded into wider or mixed-radix counters, for example seconds/minutes or BCD digits for the 7-segment display path. It sits between clock-enable generators (prescalers) and display or timing logic.

---
 rtl/mod_count.sv | 69 ++++++
 1 files changed

// File: rtl/mod_count.sv
// Up/down modulo counter with parallel load, wrap-or-saturate ends, and
// terminal-count / carry outputs for cascading into wider or mixed-radix chains.
module mod_count #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cen_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] val_o,
    output logic             tc_o,
    output logic             cout_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] val_q, val_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;

    assign at_max  = (val_q == MAX_VAL);
    assign at_zero = (val_q == '0);

    assign tc_o   = up_i ? at_max : at_zero;
    assign cout_o = cen_i & tc_o & ~load_i;
    assign val_o  = val_q;
    assign wrap_o = wrap_q;

    // End cases are decoded explicitly so non-power-of-two ranges never
    // depend on natural binary rollover.
    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
        end else if (cen_i) begin
            if (up_i) begin
                if (at_max) begin
                    val_d = SATURATE ? val_q : '0;
                end else begin
                    val_d = val_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    val_d = SATURATE ? val_q : MAX_VAL;
                end else begin
                    val_d = val_q - WIDTH'(1);
                end
            end
        end
    end

    assign wrap_d = !SATURATE && cen_i && !load_i && tc_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            wrap_q <= wrap_d;
        end
    end

endmodule
